// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline sequencing controller for the 5-stage RV32I core.
//   Detects load-use hazards between the instruction in IF/ID and a load in
//   EX, holds the front end for LOAD_LAT cycles while bubbling ID/EX, and
//   squashes wrong-path instructions when EX resolves a taken branch or jump.
//   Keeps saturating counters of stall cycles and redirect flushes.
//
// Parameters
//   LOAD_LAT : total stall cycles per load-use hazard (1..15)
//   CNT_W    : width of the stall/flush performance counters
//
// Ports
//   clk          : core clock, all state on rising edge
//   rst          : synchronous active-high reset
//   id_instr     : raw instruction currently in IF/ID
//   ex_valid     : EX holds a real (non-bubble) instruction
//   ex_opcode    : decoded opcode of the EX instruction (0..36)
//   ex_rd        : destination register of the EX instruction
//   br_taken     : EX resolved a taken branch/JAL/JALR this cycle
//   pc_we        : PC register write enable
//   if_id_we     : IF/ID register write enable
//   if_id_flush  : load NOP into IF/ID
//   id_ex_bubble : load an all-zero bubble into ID/EX
//   pc_sel       : 1 = branch target from EX, 0 = PC+4
//   ld_stall     : controller is holding for a load-use hazard
//   stall_cnt    : saturating count of stall cycles
//   flush_cnt    : saturating count of taken-branch flushes
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             ex_valid,
  input  logic [5:0]       ex_opcode,
  input  logic [4:0]       ex_rd,
  input  logic             br_taken,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pc_sel,
  output logic             ld_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_LDSTALL = 1'b1;

  // Counter reload for the remaining stall cycles after the RUN-state cycle
  // that detected the hazard.
  localparam logic [3:0] LAT_RELOAD = 4'(LOAD_LAT - 1);

  localparam logic [5:0] OPC_LOAD_LO = 6'd10;
  localparam logic [5:0] OPC_LOAD_HI = 6'd14;

  logic [0:0]       r_state;
  logic [3:0]       r_lat_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [6:0] w_major;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_ex_is_load;
  logic       w_hazard;
  logic       w_redirect;
  logic       w_stalling;
  logic       w_unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  assign w_major       = id_instr[6:0];
  assign w_rs1         = id_instr[19:15];
  assign w_rs2         = id_instr[24:20];
  assign w_unused_bits = ^{id_instr[31:25], id_instr[14:7]};

  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_major)
      7'b1100111: w_uses_rs1 = 1'b1;                      // JALR
      7'b1100011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end // branch
      7'b0000011: w_uses_rs1 = 1'b1;                      // load
      7'b0100011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end // store
      7'b0010011: w_uses_rs1 = 1'b1;                      // OP-IMM
      7'b0110011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end // OP
      default: begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
      end
    endcase
  end

  assign w_ex_is_load = ex_valid && (ex_opcode >= OPC_LOAD_LO) &&
                        (ex_opcode <= OPC_LOAD_HI);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign w_hazard = w_ex_is_load && (ex_rd != 5'd0) &&
                    ((w_uses_rs1 && (w_rs1 == ex_rd)) ||
                     (w_uses_rs2 && (w_rs2 == ex_rd)));

  // A bubble in EX cannot redirect even if br_taken glitches high.
  assign w_redirect = ex_valid && br_taken;

  assign w_stalling = (r_state == S_LDSTALL) || w_hazard;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_sel       = 1'b0;
    ld_stall     = 1'b0;
    if (rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_redirect) begin
      // Redirect beats any stall: the hazard consumer is on the wrong path.
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_stalling) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
      ld_stall     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_lat_cnt   <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (w_redirect) begin
      r_state     <= S_RUN;
      r_lat_cnt   <= 4'd0;
      r_flush_cnt <= sat_inc(r_flush_cnt);
    end else if (r_state == S_LDSTALL) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
      if (r_lat_cnt == 4'd1) begin
        r_state   <= S_RUN;
        r_lat_cnt <= 4'd0;
      end else begin
        r_lat_cnt <= r_lat_cnt - 4'd1;
      end
    end else if (w_hazard) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
      if (LOAD_LAT > 1) begin
        r_state   <= S_LDSTALL;
        r_lat_cnt <= LAT_RELOAD;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Two instances share the stimulus:
//   u_a with LOAD_LAT=1 and u_b with LOAD_LAT=3. Inputs change on the falling
//   edge; outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  localparam logic [31:0] I_ADD  = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_ADDI = 32'h00100093; // addi x1,x0,1
  localparam logic [31:0] I_LUI  = 32'h123452B7; // lui  x5,0x12345 (rs1 field=8)
  localparam logic [31:0] I_SW   = 32'h00512023; // sw   x5,0(x2)
  localparam logic [31:0] I_NOP  = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      id_instr;
  logic             ex_valid;
  logic [5:0]       ex_opcode;
  logic [4:0]       ex_rd;
  logic             br_taken;

  logic             a_pc_we, a_if_id_we, a_flush, a_bubble, a_pc_sel, a_ld_stall;
  logic [CNT_W-1:0] a_stall_cnt, a_flush_cnt;
  logic             b_pc_we, b_if_id_we, b_flush, b_bubble, b_pc_sel, b_ld_stall;
  logic [CNT_W-1:0] b_stall_cnt, b_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(CNT_W)) u_a (
    .clk(clk), .rst(rst), .id_instr(id_instr), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .br_taken(br_taken),
    .pc_we(a_pc_we), .if_id_we(a_if_id_we), .if_id_flush(a_flush),
    .id_ex_bubble(a_bubble), .pc_sel(a_pc_sel), .ld_stall(a_ld_stall),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(CNT_W)) u_b (
    .clk(clk), .rst(rst), .id_instr(id_instr), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .br_taken(br_taken),
    .pc_we(b_pc_we), .if_id_we(b_if_id_we), .if_id_flush(b_flush),
    .id_ex_bubble(b_bubble), .pc_sel(b_pc_sel), .ld_stall(b_ld_stall),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs on the falling edge, then settle.
  task automatic drive(input logic r, input logic [31:0] instr, input logic v,
                       input logic [5:0] opc, input logic [4:0] rd, input logic br);
    @(negedge clk);
    rst = r; id_instr = instr; ex_valid = v; ex_opcode = opc; ex_rd = rd; br_taken = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, I_NOP, 1'b0, 6'd0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, I_NOP, 1'b0, 6'd0, 5'd0, 1'b0);
    idle();
  endtask

  initial begin
    rst = 1'b1; id_instr = I_NOP; ex_valid = 1'b0; ex_opcode = 6'd0;
    ex_rd = 5'd0; br_taken = 1'b0;

    // Reset state and release
    drive(1'b1, I_ADD, 1'b1, 6'd12, 5'd5, 1'b0);
    drive(1'b1, I_ADD, 1'b1, 6'd12, 5'd5, 1'b0);
    chk("rst_pc_we",    a_pc_we, 0);
    chk("rst_if_id_we", a_if_id_we, 0);
    chk("rst_flush",    a_flush, 1);
    chk("rst_bubble",   a_bubble, 1);
    chk("rst_pc_sel",   a_pc_sel, 0);
    chk("rst_ld_stall", a_ld_stall, 0);
    chk("rst_stall_cnt", a_stall_cnt, 0);
    chk("rst_flush_cnt", a_flush_cnt, 0);
    idle();
    chk("rel_pc_we",    a_pc_we, 1);
    chk("rel_ld_stall", a_ld_stall, 0);
    chk("rel_bubble",   a_bubble, 0);

    // LOAD_LAT=1: lw x5 in EX, add x6,x5,x7 in ID
    do_reset();
    drive(1'b0, I_ADD, 1'b1, 6'd12, 5'd5, 1'b0);
    chk("l1_pc_we",    a_pc_we, 0);
    chk("l1_if_id_we", a_if_id_we, 0);
    chk("l1_bubble",   a_bubble, 1);
    chk("l1_ld_stall", a_ld_stall, 1);
    drive(1'b0, I_ADD, 1'b0, 6'd0, 5'd0, 1'b0);
    chk("l1_resume_pc_we", a_pc_we, 1);
    chk("l1_resume_stall", a_ld_stall, 0);
    chk("l1_stall_cnt",    a_stall_cnt, 1);

    // LOAD_LAT=3: stall lasts exactly three cycles
    do_reset();
    drive(1'b0, I_ADD, 1'b1, 6'd12, 5'd5, 1'b0);
    chk("l3_c1_stall", b_ld_stall, 1);
    drive(1'b0, I_ADD, 1'b0, 6'd0, 5'd0, 1'b0);
    chk("l3_c2_stall", b_ld_stall, 1);
    chk("l3_c2_pc_we", b_pc_we, 0);
    drive(1'b0, I_ADD, 1'b0, 6'd0, 5'd0, 1'b0);
    chk("l3_c3_stall", b_ld_stall, 1);
    chk("l3_c3_bubble", b_bubble, 1);
    drive(1'b0, I_ADD, 1'b0, 6'd0, 5'd0, 1'b0);
    chk("l3_run_stall", b_ld_stall, 0);
    chk("l3_run_pc_we", b_pc_we, 1);
    chk("l3_stall_cnt", b_stall_cnt, 3);

    // Redirect together with a hazard: redirect wins, no stall counted
    do_reset();
    drive(1'b0, I_ADD, 1'b1, 6'd12, 5'd5, 1'b1);
    chk("rd_pc_sel",   a_pc_sel, 1);
    chk("rd_flush",    a_flush, 1);
    chk("rd_bubble",   a_bubble, 1);
    chk("rd_pc_we",    a_pc_we, 1);
    chk("rd_if_id_we", a_if_id_we, 1);
    chk("rd_ld_stall", a_ld_stall, 0);
    idle();
    chk("rd_flush_cnt_a", a_flush_cnt, 1);
    chk("rd_stall_cnt_a", a_stall_cnt, 0);
    chk("rd_flush_cnt_b", b_flush_cnt, 1);
    chk("rd_stall_cnt_b", b_stall_cnt, 0);
    chk("rd_after_b_stall", b_ld_stall, 0);

    // LOAD_LAT=3: redirect in the second LDSTALL cycle aborts the stall
    do_reset();
    drive(1'b0, I_ADD, 1'b1, 6'd12, 5'd5, 1'b0);
    drive(1'b0, I_ADD, 1'b0, 6'd0, 5'd0, 1'b0);
    chk("ab_ldstall1", b_ld_stall, 1);
    drive(1'b0, I_ADD, 1'b1, 6'd30, 5'd1, 1'b1);
    chk("ab_pc_sel",   b_pc_sel, 1);
    chk("ab_pc_we",    b_pc_we, 1);
    chk("ab_flush",    b_flush, 1);
    chk("ab_ld_stall", b_ld_stall, 0);
    drive(1'b0, I_ADD, 1'b0, 6'd0, 5'd0, 1'b0);
    chk("ab_run_stall", b_ld_stall, 0);
    chk("ab_run_pc_we", b_pc_we, 1);
    chk("ab_stall_cnt", b_stall_cnt, 2);
    chk("ab_flush_cnt", b_flush_cnt, 1);

    // Edge cases
    do_reset();
    drive(1'b0, I_ADDI, 1'b1, 6'd12, 5'd0, 1'b0);
    chk("x0_pc_we",    a_pc_we, 1);
    chk("x0_ld_stall", a_ld_stall, 0);
    drive(1'b0, I_LUI, 1'b1, 6'd12, 5'd5, 1'b0);
    chk("lui_x5_stall", a_ld_stall, 0);
    drive(1'b0, I_LUI, 1'b1, 6'd12, 5'd8, 1'b0);
    chk("lui_x8_stall", a_ld_stall, 0);
    chk("lui_x8_pc_we", a_pc_we, 1);
    drive(1'b0, I_ADD, 1'b0, 6'd12, 5'd5, 1'b1);
    chk("inv_br_pc_sel", a_pc_sel, 0);
    chk("inv_br_pc_we",  a_pc_we, 1);
    drive(1'b0, I_SW, 1'b1, 6'd10, 5'd5, 1'b0);
    chk("sw_rs2_stall", a_ld_stall, 1);
    drive(1'b0, I_ADD, 1'b1, 6'd15, 5'd5, 1'b0);
    chk("non_load_stall", a_ld_stall, 0);
    idle();
    chk("edge_flush_cnt", a_flush_cnt, 0);
    chk("edge_stall_cnt", a_stall_cnt, 1);

    // Counter saturation
    do_reset();
    drive(1'b0, I_ADD, 1'b1, 6'd12, 5'd5, 1'b0);
    repeat (65540) @(posedge clk);
    idle();
    chk("sat_stall_cnt_a", a_stall_cnt, 32'h0000FFFF);
    chk("sat_stall_cnt_b", b_stall_cnt, 32'h0000FFFF);
    chk("sat_flush_cnt",   a_flush_cnt, 0);
    chk("sat_run_pc_we",   a_pc_we, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core. It watches the instruction held in IF/ID and the instruction in EX (decoded 6-bit opcode numbering from the decode stage). It generates PC/IF-ID write enables, IF-ID flush, ID-EX bubble insertion and PC redirect select. It enforces load-use interlocks with a configurable load latency, squashes wrong-path instructions on taken branches and jumps, and keeps saturating stall/flush performance counters.

Parameters:
LOAD_LAT, 1, total stall cycles per load-use hazard (legal range 1..15)
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous, active-high reset
id_instr  in  32  raw instruction currently in IF/ID
ex_valid  in  1  EX stage holds a real (non-bubble) instruction
ex_opcode  in  6  decoded opcode of EX instruction (decode numbering 0..36)
ex_rd  in  5  destination register of EX instruction
br_taken  in  1  EX resolved taken branch/JAL/JALR this cycle
pc_we  out  1  PC register write enable
if_id_we  out  1  IF/ID register write enable
if_id_flush  out  1  load NOP (0x00000013) into IF/ID
id_ex_bubble  out  1  load all-zero bubble into ID/EX, ex_valid=0 next cycle
pc_sel  out  1  1 = PC takes branch target from EX, 0 = PC+4
ld_stall  out  1  controller is in a load-use stall (status)
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Source decode from id_instr: rs1=[19:15], rs2=[24:20]. uses_rs1 for major opcodes 1100111, 1100011, 0000011, 0100011, 0010011, 0110011. uses_rs2 for 1100011, 0100011, 0110011 only.
- ex_is_load = ex_valid && ex_opcode in 10..14.
- hazard = ex_is_load && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)).
- FSM states: RUN, LDSTALL. A 4-bit down-counter lat_cnt is used only in LDSTALL.
- Outputs are combinational from the current state and inputs; the state and counters are registered.
- Priority 1, redirect (ex_valid && br_taken, either state): pc_sel=1, pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1. Next state is RUN and lat_cnt is cleared. flush_cnt increments. A pending load stall is aborted.
- Priority 2, RUN with hazard: pc_we=0, if_id_we=0, id_ex_bubble=1, if_id_flush=0, ld_stall=1. stall_cnt increments. If LOAD_LAT>1, go to LDSTALL with lat_cnt=LOAD_LAT-1; otherwise stay in RUN.
- LDSTALL without redirect: same outputs as priority 2. lat_cnt decrements each cycle. Return to RUN when lat_cnt==1. The stall is exactly LOAD_LAT cycles total.
- Default (RUN, no hazard, no redirect): pc_we=1, if_id_we=1, pc_sel=0, if_id_flush=0, id_ex_bubble=0, ld_stall=0.
- Counters saturate at all-ones and never wrap.
- Reset: state=RUN, lat_cnt=0, stall_cnt=0, flush_cnt=0. While rst=1, outputs are forced to pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1, pc_sel=0, ld_stall=0. Reset asserted mid-stall drops the stall immediately. The first cycle after reset is a normal RUN cycle.
- A redirect and a hazard in the same cycle: the redirect wins. No stall cycle is counted, because the hazard consumer is wrong-path.
- An ex_rd==0 load never stalls. br_taken with ex_valid=0 is ignored.

Test Plan:
- Reset, then release: while rst=1, pc_we=0, if_id_flush=1, id_ex_bubble=1, counters 0. The cycle after release gives pc_we=1 with state RUN.
- LOAD_LAT=1. EX holds LW (opcode 12, ex_rd=5), id_instr=ADD x6,x5,x7 (0x00728333) -> exactly one cycle with pc_we=0, if_id_we=0, id_ex_bubble=1. Then, with ex_valid=0, resume. stall_cnt=1.
- LOAD_LAT=3, same hazard with ex_valid dropping after the bubble -> ld_stall high exactly 3 cycles, stall_cnt=3, then RUN.
- ex_valid=1, br_taken=1, with a hazard-causing id_instr present -> pc_sel=1, if_id_flush=1, id_ex_bubble=1, pc_we=1. flush_cnt=1, stall_cnt unchanged.
- LOAD_LAT=3, br_taken asserted in the 2nd LDSTALL cycle -> redirect outputs that cycle, next cycle RUN with ld_stall=0. stall_cnt=2.
- Edge cases: LW with ex_rd=0 against rs1=0 -> no stall. LUI (id_instr=0x123452B7) after LW x5 -> no stall because rs1 is unused. Drive 65540 stalls with CNT_W=16 -> stall_cnt holds at 0xFFFF.
